// File: rtl/ads5281_deser_if.sv
// Bus between the ADS5281 LVDS front-end and the serial-to-parallel receiver.
// master: drives serial lanes and the align request (ADC side / stimulus).
// slave : the deserializer.
interface ads5281_deser_if #(
  parameter int NCH   = 8,
  parameter int WIDTH = 12
);
  logic [NCH-1:0]       sdata;
  logic                 align_req;
  logic [NCH*WIDTH-1:0] data_out;
  logic                 data_valid;
  logic                 locked;
  logic                 align_err;
  logic [3:0]           slip_cnt;

  modport master (
    output sdata, align_req,
    input  data_out, data_valid, locked, align_err, slip_cnt
  );

  modport slave (
    input  sdata, align_req,
    output data_out, data_valid, locked, align_err, slip_cnt
  );
endinterface

// File: rtl/ads5281_deser.sv
// ADS5281 LVDS receiver: per-lane LSB-first shift registers, a shared phase
// counter that marks the word boundary, and a bit-slip aligner that locks the
// boundary onto the ADC sync pattern seen on lane 0.
//
// state  | meaning
// S_IDLE | not aligned, no strobes; waits for an ALIGN_REQ rising edge
// S_ALIGN| comparing lane-0 words with SYNC_WORD at each boundary
// S_SLIP | one-cycle phase-counter hold, moves the boundary one bit later
// S_RUN  | locked, DATA_VALID at every boundary
module ads5281_deser #(
  parameter int               NCH        = 8,
  parameter int               WIDTH      = 12,
  parameter logic [WIDTH-1:0] SYNC_WORD  = 12'h03F,
  parameter int               LOCK_COUNT = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  ads5281_deser_if.slave bus
);

  localparam int              PW         = $clog2(WIDTH);
  localparam int              MW         = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0]   PH_LAST    = PW'(WIDTH - 1);
  localparam logic [3:0]      SLIP_MAX   = 4'(WIDTH);
  localparam logic [MW-1:0]   MATCH_LAST = MW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_SLIP, S_RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NCH-1:0]       r_sdata_q;
  logic [WIDTH-1:0]     r_sr [NCH];
  logic [PW-1:0]        r_phase;
  logic                 r_req_q;
  logic [NCH*WIDTH-1:0] r_data;
  logic                 r_valid;
  logic                 r_err;
  logic                 r_discard;
  logic [3:0]           r_slip_cnt;
  logic [MW-1:0]        r_match;

  logic                 w_boundary;
  logic                 w_req_rise;
  logic                 w_valid_nxt;
  logic                 w_err_nxt;
  logic                 w_discard_nxt;
  logic [3:0]           w_slip_nxt;
  logic [MW-1:0]        w_match_nxt;

  assign w_boundary = (r_phase == PH_LAST);
  assign w_req_rise = bus.align_req & ~r_req_q;

  // Input flop, then per-lane shift toward bit 0 so the first bit ends up as the LSB.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sdata_q <= '0;
      for (int i = 0; i < NCH; i++) r_sr[i] <= '0;
    end else begin
      r_sdata_q <= bus.sdata;
      for (int i = 0; i < NCH; i++) r_sr[i] <= {r_sdata_q[i], r_sr[i][WIDTH-1:1]};
    end
  end

  // Word phase counter; holding it for one cycle in S_SLIP delays every later boundary by a bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
    end else if (r_state != S_SLIP) begin
      r_phase <= w_boundary ? '0 : r_phase + PW'(1);
    end
  end

  // Capture all lanes at every boundary; in RUN this is also the strobe instant, so data holds between strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
    end else if (w_boundary) begin
      for (int i = 0; i < NCH; i++) r_data[i*WIDTH +: WIDTH] <= r_sr[i];
    end
  end

  // FSM state and aligner bookkeeping registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_req_q    <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_discard  <= 1'b0;
      r_slip_cnt <= '0;
      r_match    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_q    <= bus.align_req;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      r_discard  <= w_discard_nxt;
      r_slip_cnt <= w_slip_nxt;
      r_match    <= w_match_nxt;
    end
  end

  // Next-state logic; a request edge overrides whatever the current state would do this cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = r_err;
    w_discard_nxt = r_discard;
    w_slip_nxt    = r_slip_cnt;
    w_match_nxt   = r_match;
    if (w_req_rise) begin
      w_state_nxt   = S_ALIGN;
      w_err_nxt     = 1'b0;
      w_discard_nxt = 1'b1;
      w_slip_nxt    = '0;
      w_match_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_ALIGN: begin
          if (w_boundary) begin
            // The first word after (re)entering ALIGN may straddle the old framing.
            if (r_discard) begin
              w_discard_nxt = 1'b0;
            end else if (r_sr[0] == SYNC_WORD) begin
              w_match_nxt = r_match + MW'(1);
              if (r_match == MATCH_LAST) w_state_nxt = S_RUN;
            end else begin
              w_match_nxt = '0;
              if (r_slip_cnt != SLIP_MAX) w_slip_nxt = r_slip_cnt + 4'd1;
              w_state_nxt = S_SLIP;
            end
          end
        end
        S_SLIP: begin
          w_discard_nxt = 1'b1;
          if (r_slip_cnt == SLIP_MAX) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_ALIGN;
          end
        end
        S_RUN: begin
          w_valid_nxt = w_boundary;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign bus.locked     = (r_state == S_RUN);
  assign bus.align_err  = r_err;
  assign bus.slip_cnt   = r_slip_cnt;

endmodule

// File: tb/tb_ads5281_deser.sv
// Bench for ads5281_deser. The stimulus side is a framed word transmitter:
// every lane sends whole 12-bit words LSB first, with the word MSB landing on
// edges 12m-2+d_ofs (edges counted from reset release). The scoreboard keys
// each sent word by the edge its MSB is sampled on and expects it on DATA_OUT
// with DATA_VALID after that edge + 2.
module tb_ads5281_deser;
  localparam int          NCH        = 8;
  localparam int          WIDTH      = 12;
  localparam int          LOCK_COUNT = 16;
  localparam logic [11:0] SYNC       = 12'h03F;

  localparam int M_SYNC   = 0;
  localparam int M_DESKEW = 1;
  localparam int M_CONST  = 2;
  localparam int M_RAND   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ads5281_deser_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  ads5281_deser #(
    .NCH(NCH), .WIDTH(WIDTH), .SYNC_WORD(SYNC), .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_k   = 0;
  int d_ofs    = 0;
  int mode     = M_SYNC;
  logic [11:0] c_lane3 = 12'h0;
  logic [11:0] c_other = 12'h0;
  logic [11:0] fw [NCH];
  logic [NCH*WIDTH-1:0] words_at [int];

  bit sb_en     = 1'b0;
  bit have_last = 1'b0;
  int last_v    = 0;
  logic [NCH*WIDTH-1:0] last_data;

  typedef struct {
    logic [11:0] w3;
    logic [11:0] wo;
    logic [11:0] e3;
    logic [11:0] eo;
  } vec_t;
  vec_t tbl [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_k <= 0;
    else        edge_k <= edge_k + 1;
  end

  function automatic logic [11:0] pick(input int m, input int lane);
    case (m)
      M_CONST: return (lane == 3) ? c_lane3 : c_other;
      M_RAND:  return 12'($urandom);
      default: return SYNC;
    endcase
  endfunction

  // Transmitter: the value driven now is sampled at edge k1.
  always @(negedge clk) begin
    int k1, p;
    logic [NCH-1:0] sd;
    logic [NCH*WIDTH-1:0] pk;
    k1 = edge_k + 1;
    p  = (k1 + 1 - d_ofs + 24) % 12;
    if (p == 0) for (int i = 0; i < NCH; i++) fw[i] = pick(mode, i);
    for (int i = 0; i < NCH; i++) sd[i] = (mode == M_DESKEW) ? k1[0] : fw[i][p];
    bus.sdata = sd;
    if (p == 11) begin
      for (int i = 0; i < NCH; i++) pk[i*WIDTH +: WIDTH] = fw[i];
      words_at[k1] = pk;
    end
  end

  // Scoreboard: data content, strobe period and hold between strobes.
  always @(negedge clk) begin
    if (sb_en && rst_n) begin
      if (bus.data_valid) begin
        n_checks++;
        if (!words_at.exists(edge_k - 2)) begin
          n_errors++;
          $display("FAIL sb_data edge %0d: strobe with no word sent at edge %0d", edge_k, edge_k - 2);
        end else if (bus.data_out !== words_at[edge_k - 2]) begin
          n_errors++;
          $display("FAIL sb_data edge %0d: got %h expected %h", edge_k, bus.data_out, words_at[edge_k - 2]);
        end
        if (have_last) begin
          n_checks++;
          if (edge_k - last_v != WIDTH) begin
            n_errors++;
            $display("FAIL sb_period: got %0d expected %0d", edge_k - last_v, WIDTH);
          end
        end
        have_last = 1'b1;
        last_v    = edge_k;
        last_data = bus.data_out;
      end else if (have_last) begin
        n_checks++;
        if (bus.data_out !== last_data) begin
          n_errors++;
          $display("FAIL sb_hold edge %0d: got %h expected %h", edge_k, bus.data_out, last_data);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sb_on();
    have_last = 1'b0;
    sb_en     = 1'b1;
  endtask

  task automatic do_reset(input int d);
    sb_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.align_req = 1'b0;
    d_ofs = d;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic req_rise(output int e0);
    bus.align_req = 1'b1;
    e0 = edge_k + 1;
  endtask

  task automatic run_count(input int n, output int nv);
    nv = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.data_valid) nv++;
    end
  endtask

  task automatic wait_lock(input int budget, output bit ok, output int le, output int nv);
    ok = 1'b0; le = -1; nv = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.data_valid) nv++;
      if (bus.locked) begin
        ok = 1'b1; le = edge_k;
        break;
      end
    end
    check("lock_reached", int'(ok), 1);
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.data_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL wait_valid: got no strobe expected one within %0d cycles", budget);
    end
  endtask

  // Lock lands on the 17th boundary (1 discarded + LOCK_COUNT) strictly after the request edge.
  function automatic int exp_lock(input int e0);
    return (e0 / WIDTH + 1) * WIDTH + LOCK_COUNT * WIDTH;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data_out"}, int'(bus.data_out != '0), 0);
    check({tag, "_valid"},    int'(bus.data_valid), 0);
    check({tag, "_locked"},   int'(bus.locked), 0);
    check({tag, "_err"},      int'(bus.align_err), 0);
    check({tag, "_slip"},     int'(bus.slip_cnt), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, le, nv;
    bit ok;
    for (int i = 0; i < NCH; i++) fw[i] = SYNC;
    bus.align_req = 1'b0;
    bus.sdata     = '0;
    tbl[0] = '{12'hB00, 12'h200, 12'hB00, 12'h200};
    tbl[1] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000};
    tbl[2] = '{12'h001, 12'h800, 12'h001, 12'h800};
    tbl[3] = '{12'hA5A, 12'h3C3, 12'hA5A, 12'h3C3};

    // Reset state and aligned lock at a random request offset; level kept high through lock.
    mode = M_SYNC;
    do_reset(0);
    check_zero_outputs("post_reset");
    tick(20 + int'($urandom_range(0, 11)));
    req_rise(e0);
    wait_lock(400, ok, le, nv);
    check("aligned_lock_edge", le, exp_lock(e0));
    check("aligned_slip", int'(bus.slip_cnt), 0);
    check("aligned_err", int'(bus.align_err), 0);
    check("aligned_valid_before_lock", nv, 0);
    bus.align_req = 1'b0;
    sb_on();
    run_count(60, nv);
    check("aligned_strobes_60", nv, 5);

    // Constant-word vectors after lock.
    mode = M_CONST;
    for (int v = 0; v < 4; v++) begin
      c_lane3 = tbl[v].w3;
      c_other = tbl[v].wo;
      repeat (4) wait_valid(30);
      for (int ln = 0; ln < NCH; ln++)
        check($sformatf("vec%0d_lane%0d", v, ln), int'(bus.data_out[ln*WIDTH +: WIDTH]),
              int'((ln == 3) ? tbl[v].e3 : tbl[v].eo));
    end

    // Random data, scoreboard-checked; exactly one strobe per word.
    mode = M_RAND;
    run_count(300, nv);
    check("random_strobes_300", nv, 25);

    // Re-align from RUN with the request edge on a boundary: restart wins, no strobe there.
    mode = M_SYNC;
    tick(30);
    while ((edge_k + 1) % WIDTH != 0) tick(1);
    sb_en = 1'b0;
    req_rise(e0);
    tick(1);
    check("realign_locked_drop", int'(bus.locked), 0);
    check("realign_no_strobe_on_edge", int'(bus.data_valid), 0);
    tick(2);
    bus.align_req = 1'b0;
    wait_lock(400, ok, le, nv);
    check("realign_lock_edge", le, exp_lock(e0));
    check("realign_valid_before_lock", nv, 0);
    check("realign_err", int'(bus.align_err), 0);

    // Offset framing needing 7 slips.
    do_reset(7);
    tick(15);
    req_rise(e0);
    wait_lock(1000, ok, le, nv);
    bus.align_req = 1'b0;
    check("offset_slip", int'(bus.slip_cnt), 7);
    check("offset_locked", int'(bus.locked), 1);
    check("offset_valid_before_lock", nv, 0);
    sb_on();
    run_count(60, nv);
    check("offset_strobes_60", nv, 5);

    // Deskew pattern: all phases fail.
    do_reset(0);
    mode = M_DESKEW;
    tick(20);
    req_rise(e0);
    tick(3);
    bus.align_req = 1'b0;
    nv = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.data_valid) nv++;
      if (bus.align_err) begin ok = 1'b1; break; end
    end
    check("deskew_err", int'(bus.align_err), 1);
    check("deskew_slip", int'(bus.slip_cnt), 12);
    run_count(40, le);
    check("deskew_valid", nv + le, 0);
    check("deskew_locked", int'(bus.locked), 0);
    check("deskew_err_sticky", int'(bus.align_err), 1);

    // Recovery: a new request clears the sticky error and re-locks on sync.
    mode = M_SYNC;
    tick(30);
    req_rise(e0);
    tick(1);
    check("recover_err_cleared", int'(bus.align_err), 0);
    check("recover_slip_cleared", int'(bus.slip_cnt), 0);
    tick(2);
    bus.align_req = 1'b0;
    wait_lock(600, ok, le, nv);
    check("recover_slip", int'(bus.slip_cnt), 0);
    sb_on();
    run_count(36, nv);
    check("recover_strobes_36", nv, 3);

    // Asynchronous reset mid-stream while a strobe is high.
    mode = M_RAND;
    tick(24);
    wait_valid(30);
    sb_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_count(60, nv);
    check("after_reset_valid", nv, 0);
    check("after_reset_locked", int'(bus.locked), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
